microcode_sequencer: RTL and testbench
======================================

Name: microcode_sequencer

Overview:
- Microprogrammed control stage directly upstream of the datapath top.
- Holds a loadable microcode store and sequences through it, driving the 55-bit ControlWord each cycle.
- Branches on the datapath status flags Zero, Negative, CarryOut and Overflow, which are fed back from the datapath.
- Replaces hand-driven control words with stored micro-programs.

Parameters:
- ADDR_W, 6, micro-address width; store depth = 2**ADDR_W.
- CW_W, 55, control word width; fixed by the datapath field map.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- LoadEn  in  1  write strobe for the microcode store.
- LoadAddr  in  ADDR_W  store write address.
- LoadData  in  CW_W+4+ADDR_W  microinstruction = {BranchAddr, Cond[3:0], CW[54:0]}.
- Start  in  1  begin execution at StartAddr.
- StartAddr  in  ADDR_W  entry micro-address.
- Zero, Negative, CarryOut, Overflow  in  1 each  datapath flags (combinational response to the current ControlWord).
- ControlWord  out  CW_W  control word to the datapath.
- MicroPC  out  ADDR_W  current micro-address.
- Running  out  1  high in RUN.
- Halted  out  1  high in HALTED.

Behaviour:
- States: IDLE, RUN, HALTED.
- Reset, from any state including mid-program: state=IDLE, MicroPC=0, Running=0, Halted=0. Store contents are not cleared.
- ControlWord:
  - RUN: combinational read of store[MicroPC][54:0].
  - IDLE/HALTED: all zeros. This forces RW (bit 32)=0, so no register write occurs.
- Load:
  - LoadEn in IDLE or HALTED writes store[LoadAddr]=LoadData at the clock edge.
  - LoadEn in RUN is ignored.
- Start:
  - Start in IDLE or HALTED gives MicroPC=StartAddr and state=RUN on the next edge.
  - Start in RUN is ignored.
  - If Start and LoadEn are both high in IDLE, both take effect. A load to StartAddr is visible on the first RUN cycle.
- RUN, each cycle: evaluate Cond of the current instruction against the current flags to form the next MicroPC.
  - 0 NEXT: MicroPC+1.
  - 1 JMP: BranchAddr.
  - 2 JZ: Zero ? BranchAddr : +1.
  - 3 JNZ: !Zero ? BranchAddr : +1.
  - 4 JN: Negative ? BranchAddr : +1.
  - 5 JC: CarryOut ? BranchAddr : +1.
  - 6 JV: Overflow ? BranchAddr : +1.
  - 7 HALT: the instruction's control word is still issued that cycle (its register write happens). Next edge: state=HALTED, MicroPC holds.
  - 8-15: reserved, behave as NEXT.
- +1 wraps from 2**ADDR_W-1 to 0.
- Latency:
  - One instruction per cycle; a taken branch has no penalty.
  - Flags are sampled in the same cycle as the instruction that produced them.
- Running = (state==RUN). Halted = (state==HALTED).

Optional Feature:
- Macro: MICROCODE_SEQUENCER_STEP_EN.
- Enabled:
  - Adds input port Step (1 bit).
  - In HALTED, a Step pulse issues one instruction at MicroPC: ControlWord is driven for that cycle and the next MicroPC is computed normally. State then stays HALTED, unless the instruction is HALT, in which case MicroPC holds.
  - Step in IDLE or RUN is ignored.
  - Start takes priority over Step.
- Disabled: no Step port; HALTED exits only via Start or Reset.

Decomposition:
- Package microcode_pkg holds:
  - state enum (IDLE, RUN, HALTED);
  - Cond code constants COND_NEXT..COND_HALT;
  - field offsets: CW [54:0], Cond [58:55], BranchAddr above Cond;
  - CW field positions: DA 54:52, AA 51:49, BA 48:46, MB 45, FS 44:41, shift type 40:38, shift amount 37:34, MD 33, RW 32, constant B 31:16, constant D 15:0.
- One sub-module, microcode_store: synchronous write, asynchronous read, depth 2**ADDR_W.

Test Plan:
- Reset then idle: ControlWord=0, MicroPC=0, Running=0, Halted=0.
- Reset asserted while in RUN at MicroPC=5: next cycle IDLE, MicroPC=0.
- Load entries 0..2 as NEXT, NEXT, HALT with distinct CWs, then Start at address 0: ControlWord equals CW0, CW1, CW2 on consecutive cycles, then 0. Halted=1, MicroPC=2.
- Entry 4 = JZ to 10:
  - with Zero=1: next MicroPC=10;
  - with Zero=0: next MicroPC=5.
- Repeat the branch check for JNZ, JN, JC and JV on their respective flags.
- Wrap-around: entry 63 = NEXT, Start at 63: next MicroPC=0.
- LoadEn during RUN: store unchanged; re-run reads the old value. Reserved Cond=12 advances by 1.
- Step feature (macro defined): in HALTED at MicroPC=8 (NEXT), a Step pulse issues CW8 for one cycle, then MicroPC=9 and Halted=1.

Source files
------------

// File: rtl/microcode_pkg.sv
// Shared types for the microcode sequencer: state encoding, branch condition codes,
// the datapath control-word field map, and the branch-decision helper.
package microcode_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [3:0] COND_NEXT = 4'd0;
  localparam logic [3:0] COND_JMP  = 4'd1;
  localparam logic [3:0] COND_JZ   = 4'd2;
  localparam logic [3:0] COND_JNZ  = 4'd3;
  localparam logic [3:0] COND_JN   = 4'd4;
  localparam logic [3:0] COND_JC   = 4'd5;
  localparam logic [3:0] COND_JV   = 4'd6;
  localparam logic [3:0] COND_HALT = 4'd7;

  // Microinstruction layout: {BranchAddr, Cond[3:0], CW[54:0]}.
  localparam int CW_LSB   = 0;
  localparam int CW_MSB   = 54;
  localparam int COND_LSB = 55;
  localparam int COND_MSB = 58;
  localparam int BR_LSB   = 59;

  // Datapath field map of the 55-bit control word, MSB first.
  typedef struct packed {
    logic [2:0]  da;
    logic [2:0]  aa;
    logic [2:0]  ba;
    logic        mb;
    logic [3:0]  fs;
    logic [2:0]  shift_type;
    logic [3:0]  shift_amt;
    logic        md;
    logic        rw;
    logic [15:0] const_b;
    logic [15:0] const_d;
  } cw_fields_t;

  // Reserved codes 8-15 fall through to not-taken, i.e. behave as NEXT.
  function automatic logic cond_taken(input logic [3:0] cond, input logic zero,
                                      input logic negative, input logic carry,
                                      input logic overflow);
    logic taken;
    taken = 1'b0;
    case (cond)
      COND_NEXT: taken = 1'b0;
      COND_JMP:  taken = 1'b1;
      COND_JZ:   taken = zero;
      COND_JNZ:  taken = !zero;
      COND_JN:   taken = negative;
      COND_JC:   taken = carry;
      COND_JV:   taken = overflow;
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/microcode_store.sv
// Microcode store: synchronous write, asynchronous read, depth 2**ADDR_W.
module microcode_store #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 65
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/microcode_sequencer.sv
// Microprogrammed control stage: sequences a loadable store and drives the datapath ControlWord.
// Optional single-step from HALTED is enabled by defining MICROCODE_SEQUENCER_STEP_EN.
module microcode_sequencer
  import microcode_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int CW_W   = 55
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     LoadEn,
  input  logic [ADDR_W-1:0]        LoadAddr,
  input  logic [CW_W+4+ADDR_W-1:0] LoadData,
  input  logic                     Start,
  input  logic [ADDR_W-1:0]        StartAddr,
  input  logic                     Zero,
  input  logic                     Negative,
  input  logic                     CarryOut,
  input  logic                     Overflow,
`ifdef MICROCODE_SEQUENCER_STEP_EN
  input  logic                     Step,
`endif
  output logic [CW_W-1:0]          ControlWord,
  output logic [ADDR_W-1:0]        MicroPC,
  output logic                     Running,
  output logic                     Halted,
  output state_e                   dbg_state
);

  localparam int INSTR_W = CW_W + 4 + ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   upc_q, upc_d;
  logic                store_we;
  logic [INSTR_W-1:0]  instr;
  logic [CW_W-1:0]     instr_cw;
  logic [3:0]          instr_cond;
  logic [ADDR_W-1:0]   instr_br;
  logic [ADDR_W-1:0]   seq_pc;
  logic [ADDR_W-1:0]   exec_pc;
  logic                step_go;
  logic                issue;

  microcode_store #(
    .ADDR_W(ADDR_W),
    .DATA_W(INSTR_W)
  ) u_store (
    .clk  (Clock),
    .we   (store_we),
    .waddr(LoadAddr),
    .wdata(LoadData),
    .raddr(upc_q),
    .rdata(instr)
  );

  assign instr_cw   = instr[CW_W-1:0];
  assign instr_cond = instr[CW_W+3:CW_W];
  assign instr_br   = instr[INSTR_W-1:CW_W+4];
  assign seq_pc     = upc_q + ADDR_W'(1);
  assign exec_pc    = cond_taken(instr_cond, Zero, Negative, CarryOut, Overflow)
                      ? instr_br : seq_pc;

`ifdef MICROCODE_SEQUENCER_STEP_EN
  assign step_go = (state_q == HALTED) && Step && !Start;
`else
  assign step_go = 1'b0;
`endif

  assign issue = (state_q == RUN) || step_go;

  always_comb begin
    state_d  = state_q;
    upc_d    = upc_q;
    store_we = 1'b0;
    case (state_q)
      IDLE: begin
        store_we = LoadEn;
        if (Start) begin
          state_d = RUN;
          upc_d   = StartAddr;
        end
      end
      RUN: begin
        if (instr_cond == COND_HALT) state_d = HALTED;
        else                         upc_d   = exec_pc;
      end
      HALTED: begin
        store_we = LoadEn;
        if (Start) begin
          state_d = RUN;
          upc_d   = StartAddr;
        end else if (step_go && (instr_cond != COND_HALT)) begin
          upc_d = exec_pc;
        end
      end
      default: begin
        state_d = IDLE;
        upc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      upc_q   <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
    end
  end

  // Idle/halted drive zeros so RW stays low and the datapath never writes.
  assign ControlWord = issue ? instr_cw : '0;
  assign MicroPC     = upc_q;
  assign Running     = (state_q == RUN);
  assign Halted      = (state_q == HALTED);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the sequencer.
module tb_microcode_sequencer;
  import microcode_pkg::*;

  localparam int ADDR_W  = 6;
  localparam int CW_W    = 55;
  localparam int INSTR_W = 65;
  localparam int DEPTH   = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, load_en, start, step;
  logic [ADDR_W-1:0]  load_addr, start_addr;
  logic [INSTR_W-1:0] load_data;
  logic               zero, neg, carry, ovf;
  logic [CW_W-1:0]    cw;
  logic [ADDR_W-1:0]  upc;
  logic               running, halted;
  state_e             dbg_state;

  microcode_sequencer #(.ADDR_W(ADDR_W), .CW_W(CW_W)) dut (
    .Clock      (clk),
    .Reset      (rst),
    .LoadEn     (load_en),
    .LoadAddr   (load_addr),
    .LoadData   (load_data),
    .Start      (start),
    .StartAddr  (start_addr),
    .Zero       (zero),
    .Negative   (neg),
    .CarryOut   (carry),
    .Overflow   (ovf),
`ifdef MICROCODE_SEQUENCER_STEP_EN
    .Step       (step),
`endif
    .ControlWord(cw),
    .MicroPC    (upc),
    .Running    (running),
    .Halted     (halted),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [INSTR_W-1:0] mem_m [DEPTH];
  int st_m;  // 0 idle, 1 run, 2 halted
  int pc_m;

  task automatic check_eq(input string tag, input logic [INSTR_W-1:0] act,
                          input logic [INSTR_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int model_next(input logic [INSTR_W-1:0] ins, input int pc);
    int c, br, seq;
    bit t;
    c   = int'(ins[58:55]);
    br  = int'(ins[64:59]);
    seq = (pc + 1) % DEPTH;
    case (c)
      1: t = 1'b1;
      2: t = zero;
      3: t = !zero;
      4: t = neg;
      5: t = carry;
      6: t = ovf;
      default: t = 1'b0;
    endcase
    return t ? br : seq;
  endfunction

  function automatic logic [CW_W-1:0] model_cw();
    logic [INSTR_W-1:0] ins;
    ins = mem_m[pc_m];
    if (st_m == 1) return ins[CW_W-1:0];
`ifdef MICROCODE_SEQUENCER_STEP_EN
    if (st_m == 2 && step && !start) return ins[CW_W-1:0];
`endif
    return '0;
  endfunction

  task automatic model_update();
    logic [INSTR_W-1:0] ins;
    if (rst) begin
      st_m = 0;
      pc_m = 0;
      return;
    end
    ins = mem_m[pc_m];
    case (st_m)
      1: begin
        if (int'(ins[58:55]) == 7) st_m = 2;
        else pc_m = model_next(ins, pc_m);
      end
      default: begin
`ifdef MICROCODE_SEQUENCER_STEP_EN
        if (st_m == 2 && step && !start && int'(ins[58:55]) != 7)
          pc_m = model_next(ins, pc_m);
`endif
        if (load_en) mem_m[load_addr] = load_data;
        if (start) begin
          st_m = 1;
          pc_m = int'(start_addr);
        end
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    #1;
    check_eq("cw", cw, model_cw());
    check_eq("upc", upc, pc_m);
    check_eq("running", running, st_m == 1);
    check_eq("halted", halted, st_m == 2);
    @(posedge clk);
    model_update();
    @(negedge clk);
    rst = 0; load_en = 0; start = 0; step = 0;
  endtask

  function automatic logic [CW_W-1:0] rand_cw();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[CW_W-1:0];
  endfunction

  task automatic load_entry(input int addr, input int br, input int cond,
                            input logic [CW_W-1:0] w);
    logic [5:0] b;
    logic [3:0] c;
    b = br[5:0];
    c = cond[3:0];
    load_en   = 1;
    load_addr = addr[5:0];
    load_data = {b, c, w};
    tick();
  endtask

  task automatic start_at(input int a);
    start      = 1;
    start_addr = a[5:0];
    tick();
  endtask

  task automatic run_to_halt();
    for (int k = 0; k < 8 && st_m == 1; k++) tick();
    check_eq("reach_halt", halted, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  logic [CW_W-1:0] cw0, cw_a;
  bit taken, fv;

  initial begin
    rst = 1; load_en = 0; start = 0; step = 0;
    load_addr = '0; start_addr = '0; load_data = '0;
    zero = 0; neg = 0; carry = 0; ovf = 0;
    st_m = 0; pc_m = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;

    check_eq("rst_cw", cw, '0);
    check_eq("rst_upc", upc, '0);
    check_eq("rst_running", running, 1'b0);
    check_eq("rst_halted", halted, 1'b0);

    for (int i = 0; i < DEPTH; i++) load_entry(i, $urandom_range(0, 63), 0, rand_cw());

    // straight-line program ending in HALT
    cw0 = rand_cw();
    load_entry(0, 0, 0, cw0);
    load_entry(1, 0, 0, cw0 ^ 55'h1);
    load_entry(2, 0, 7, cw0 ^ 55'h2);
    start_at(0);
    check_eq("seq_cw0", cw, cw0);
    tick();
    check_eq("seq_cw1", cw, cw0 ^ 55'h1);
    tick();
    check_eq("seq_cw2", cw, cw0 ^ 55'h2);
    tick();
    check_eq("seq_cw_done", cw, '0);
    check_eq("seq_halted", halted, 1'b1);
    check_eq("seq_upc", upc, 6'd2);

    // conditional branches, each flag both ways
    load_entry(5, 0, 7, rand_cw());
    load_entry(10, 0, 7, rand_cw());
    for (int c = 2; c <= 6; c++) begin
      for (int v = 0; v < 2; v++) begin
        load_entry(4, 10, c, rand_cw());
        start_at(4);
        zero = 1'($urandom_range(0, 1)); neg = 1'($urandom_range(0, 1));
        carry = 1'($urandom_range(0, 1)); ovf = 1'($urandom_range(0, 1));
        fv = v[0];
        case (c)
          2: begin zero = fv; taken = fv; end
          3: begin zero = fv; taken = !fv; end
          4: begin neg = fv; taken = fv; end
          5: begin carry = fv; taken = fv; end
          default: begin ovf = fv; taken = fv; end
        endcase
        tick();
        check_eq($sformatf("br_c%0d_f%0d", c, v), upc, taken ? 6'd10 : 6'd5);
        run_to_halt();
      end
    end

    // address wrap
    load_entry(63, 0, 0, rand_cw());
    load_entry(0, 0, 7, rand_cw());
    start_at(63);
    tick();
    check_eq("wrap_upc", upc, 6'd0);
    run_to_halt();

    // reset in the middle of a program
    for (int i = 0; i < 6; i++) load_entry(i, 0, 0, rand_cw());
    load_entry(6, 0, 7, rand_cw());
    start_at(0);
    for (int i = 0; i < 5; i++) tick();
    check_eq("mid_upc5", upc, 6'd5);
    rst = 1;
    tick();
    check_eq("mid_rst_upc", upc, 6'd0);
    check_eq("mid_rst_running", running, 1'b0);
    check_eq("mid_rst_halted", halted, 1'b0);

    // load during RUN is ignored
    cw_a = rand_cw();
    load_entry(20, 0, 0, cw_a);
    load_entry(21, 0, 7, rand_cw());
    start_at(20);
    load_en = 1; load_addr = 6'd20; load_data = {6'd0, 4'd0, ~cw_a};
    tick();
    run_to_halt();
    start_at(20);
    check_eq("run_load_ignored", cw, cw_a);
    run_to_halt();

    // reserved condition advances by one
    load_entry(30, 45, 12, rand_cw());
    load_entry(31, 0, 7, rand_cw());
    start_at(30);
    tick();
    check_eq("reserved_upc", upc, 6'd31);
    run_to_halt();

    // simultaneous load and start from IDLE
    rst = 1;
    tick();
    cw_a = rand_cw();
    load_en = 1; load_addr = 6'd40; load_data = {6'd0, 4'd7, cw_a};
    start = 1; start_addr = 6'd40;
    tick();
    check_eq("load_start_cw", cw, cw_a);
    tick();

`ifdef MICROCODE_SEQUENCER_STEP_EN
    load_entry(8, 0, 7, rand_cw());
    start_at(8);
    tick();
    cw_a = rand_cw();
    load_entry(8, 0, 0, cw_a);
    step = 1;
    #1;
    check_eq("step_cw", cw, cw_a);
    tick();
    check_eq("step_upc", upc, 6'd9);
    check_eq("step_halted", halted, 1'b1);
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1;
      end else begin
        load_en    = ($urandom_range(0, 2) == 0);
        load_addr  = 6'($urandom_range(0, 63));
        load_data  = {6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)), rand_cw()};
        start      = ($urandom_range(0, 4) == 0);
        start_addr = 6'($urandom_range(0, 63));
        step       = ($urandom_range(0, 2) == 0);
      end
      zero  = 1'($urandom_range(0, 1));
      neg   = 1'($urandom_range(0, 1));
      carry = 1'($urandom_range(0, 1));
      ovf   = 1'($urandom_range(0, 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
